control_pipe: RTL

//   Parametrised successor of the single-cycle RV32 control decoder. Decodes the fetch-stage

---
 rtl/control_pipe_if.sv | 32 +++
 rtl/control_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe_if.sv
// Fetch-to-EX control bundle: fetched instruction and flush request in,
// registered EX-stage control fields and the fetch stall out.
interface control_pipe_if #(
    parameter int NUM_GPIO_OUT = 1
);
    logic [31:0]             instr_F;
    logic                    branch_taken_EX;
    logic [3:0]              aluop_EX;
    logic                    alusrc_EX;
    logic [1:0]              regsel_EX;
    logic                    regwrite_EX;
    logic [NUM_GPIO_OUT-1:0] gpio_we_EX;
    logic                    is_branch_EX;
    logic [2:0]              funct3_EX;
    logic                    valid_EX;
    logic                    illegal_EX;
    logic                    stall_FETCH;

    modport master (
        output instr_F, branch_taken_EX,
        input  aluop_EX, alusrc_EX, regsel_EX, regwrite_EX,
        input  gpio_we_EX, is_branch_EX, funct3_EX,
        input  valid_EX, illegal_EX, stall_FETCH
    );

    modport slave (
        input  instr_F, branch_taken_EX,
        output aluop_EX, alusrc_EX, regsel_EX, regwrite_EX,
        output gpio_we_EX, is_branch_EX, funct3_EX,
        output valid_EX, illegal_EX, stall_FETCH
    );
endinterface

// File: rtl/control_pipe.sv
// RV32 control decoder registering a control bundle into EX, with a
// multiply stall FSM, taken-branch bubble injection and GPIO CSR strobes.
// Ports: clk, rst (sync, active high), bus (slave: instr_F and
// branch_taken_EX in; *_EX control fields and stall_FETCH out).
module control_pipe #(
    parameter int          MUL_CYCLES   = 2,
    parameter int          NUM_GPIO_OUT = 1,
    parameter logic [11:0] CSR_IN_BASE  = 12'hf00,
    parameter logic [11:0] CSR_OUT_BASE = 12'hf02
) (
    input logic           clk,
    input logic           rst,
    control_pipe_if.slave bus
);
    localparam int CW = $clog2(MUL_CYCLES) + 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    typedef struct packed {
        logic [3:0]              aluop;
        logic                    alusrc;
        logic [1:0]              regsel;
        logic                    regwrite;
        logic [NUM_GPIO_OUT-1:0] gpio_we;
        logic                    is_branch;
        logic [2:0]              funct3;
        logic                    valid;
        logic                    illegal;
    } ctl_t;

    typedef enum logic {S_RUN, S_MUL} state_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [11:0] w_csr;
    logic [11:0] w_gidx;
    logic        w_ok;
    logic        w_mul;
    ctl_t        w_dec;
    ctl_t        w_ex_n;
    state_t      w_state_n;
    logic [CW-1:0] w_cnt_n;
    logic        w_stall;

    ctl_t          r_ex;
    state_t        r_state;
    logic [CW-1:0] r_cnt;

    assign w_opc  = bus.instr_F[6:0];
    assign w_f3   = bus.instr_F[14:12];
    assign w_f7   = bus.instr_F[31:25];
    assign w_csr  = bus.instr_F[31:20];
    // Unsigned 12-bit offset: addresses below the base wrap high and miss.
    assign w_gidx = w_csr - CSR_OUT_BASE;

    always_comb begin
        w_dec        = '0;
        w_dec.valid  = 1'b1;
        w_dec.funct3 = w_f3;
        w_ok         = 1'b1;
        w_mul        = 1'b0;
        unique case (1'b1)
            (w_opc == OP_R): begin
                w_dec.regsel   = 2'b10;
                w_dec.regwrite = 1'b1;
                case ({w_f7, w_f3})
                    {7'h00, 3'h0}: w_dec.aluop = 4'd3;
                    {7'h20, 3'h0}: w_dec.aluop = 4'd4;
                    {7'h00, 3'h1}: w_dec.aluop = 4'd8;
                    {7'h00, 3'h2}: w_dec.aluop = 4'd12;
                    {7'h00, 3'h3}: w_dec.aluop = 4'd13;
                    {7'h00, 3'h4}: w_dec.aluop = 4'd2;
                    {7'h00, 3'h5}: w_dec.aluop = 4'd9;
                    {7'h20, 3'h5}: w_dec.aluop = 4'd10;
                    {7'h00, 3'h6}: w_dec.aluop = 4'd1;
                    {7'h00, 3'h7}: w_dec.aluop = 4'd0;
                    {7'h01, 3'h0}: begin
                        w_dec.aluop = 4'd5;
                        w_mul       = 1'b1;
                    end
                    {7'h01, 3'h1}: begin
                        w_dec.aluop = 4'd6;
                        w_mul       = 1'b1;
                    end
                    {7'h01, 3'h3}: begin
                        w_dec.aluop = 4'd7;
                        w_mul       = 1'b1;
                    end
                    default: w_ok = 1'b0;
                endcase
            end
            (w_opc == OP_I): begin
                w_dec.alusrc   = 1'b1;
                w_dec.regsel   = 2'b10;
                w_dec.regwrite = 1'b1;
                case (w_f3)
                    3'h0: w_dec.aluop = 4'd3;
                    3'h2: w_dec.aluop = 4'd12;
                    3'h3: w_dec.aluop = 4'd13;
                    3'h4: w_dec.aluop = 4'd2;
                    3'h6: w_dec.aluop = 4'd1;
                    3'h7: w_dec.aluop = 4'd0;
                    3'h1: begin
                        w_dec.aluop = 4'd8;
                        w_ok        = (w_f7 == 7'h00);
                    end
                    default: begin
                        if (w_f7 == 7'h00)
                            w_dec.aluop = 4'd9;
                        else if (w_f7 == 7'h20)
                            w_dec.aluop = 4'd10;
                        else
                            w_ok = 1'b0;
                    end
                endcase
            end
            (w_opc == OP_LUI): begin
                w_dec.regsel   = 2'b01;
                w_dec.regwrite = 1'b1;
            end
            (w_opc == OP_BR): begin
                w_dec.is_branch = 1'b1;
                case (w_f3)
                    3'h0, 3'h1: w_dec.aluop = 4'd4;
                    3'h4, 3'h5: w_dec.aluop = 4'd12;
                    3'h6, 3'h7: w_dec.aluop = 4'd13;
                    default:    w_ok        = 1'b0;
                endcase
            end
            (w_opc == OP_JAL): begin
                w_dec.regsel   = 2'b11;
                w_dec.regwrite = 1'b1;
            end
            (w_opc == OP_JALR): begin
                w_dec.aluop    = 4'd3;
                w_dec.alusrc   = 1'b1;
                w_dec.regsel   = 2'b11;
                w_dec.regwrite = 1'b1;
                w_ok           = (w_f3 == 3'h0);
            end
            (w_opc == OP_SYS): begin
                if (w_f3 != 3'h1) begin
                    w_ok = 1'b0;
                end else if (w_csr == CSR_IN_BASE) begin
                    w_dec.regsel   = 2'b00;
                    w_dec.regwrite = 1'b1;
                end else begin
                    w_ok = 1'b0;
                    for (int i = 0; i < NUM_GPIO_OUT; i++) begin
                        if (w_gidx == 12'(i)) begin
                            w_dec.gpio_we[i] = 1'b1;
                            w_ok             = 1'b1;
                        end
                    end
                end
            end
            default: w_ok = 1'b0;
        endcase
        if (!w_ok) begin
            w_dec         = '0;
            w_dec.valid   = 1'b1;
            w_dec.illegal = 1'b1;
            w_dec.funct3  = w_f3;
            w_mul         = 1'b0;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ex_n    = r_ex;
        w_stall   = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (bus.branch_taken_EX) begin
                    w_ex_n = '0;
                end else begin
                    w_ex_n = w_dec;
                    if (w_mul && (MUL_CYCLES > 1)) begin
                        w_cnt_n   = CW'(MUL_CYCLES - 1);
                        w_state_n = S_MUL;
                    end
                end
            end
            S_MUL: begin
                w_stall = 1'b1;
                w_cnt_n = r_cnt - CW'(1);
                if (r_cnt == CW'(1))
                    w_state_n = S_RUN;
            end
            default: w_state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_ex    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ex    <= w_ex_n;
        end
    end

    assign bus.aluop_EX     = r_ex.aluop;
    assign bus.alusrc_EX    = r_ex.alusrc;
    assign bus.regsel_EX    = r_ex.regsel;
    assign bus.regwrite_EX  = r_ex.regwrite;
    assign bus.gpio_we_EX   = r_ex.gpio_we;
    assign bus.is_branch_EX = r_ex.is_branch;
    assign bus.funct3_EX    = r_ex.funct3;
    assign bus.valid_EX     = r_ex.valid;
    assign bus.illegal_EX   = r_ex.illegal;
    assign bus.stall_FETCH  = w_stall;
endmodule
